// File: rtl/shifter_pkg.sv
// shifter_pkg: mode and state encodings shared by the sequential shifter
package shifter_pkg;
  localparam logic [1:0] MODE_LSL = 2'b00;
  localparam logic [1:0] MODE_LSR = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;
  localparam logic [1:0] MODE_ROL = 2'b11;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
endpackage

// File: rtl/shift_step.sv
// shift_step: single-bit shift/rotate of value in the selected mode
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] value,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] next,
  output logic             out_bit
);
  always_comb begin
    out_bit = (mode == MODE_LSL || mode == MODE_ROL) ? value[WIDTH-1] : value[0];
    next = (mode == MODE_LSL) ? {value[WIDTH-2:0], 1'b0} :
           (mode == MODE_LSR) ? {1'b0, value[WIDTH-1:1]} :
           (mode == MODE_ASR) ? {value[WIDTH-1], value[WIDTH-1:1]} :
                                {value[WIDTH-2:0], value[WIDTH-1]};
  end
endmodule

// File: rtl/shifter_seq.sv
// shifter_seq: multi-cycle shifter, one bit per clock under start/busy/done handshake
module shifter_seq
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] from_Y,
  input  logic [1:0]       mode,
  input  logic [AMT_W-1:0] shift_amount,
  output logic [WIDTH-1:0] Y_shifted,
  output logic             carry_out,
  output logic             zero,
  output logic             busy,
  output logic             done
);
  logic [1:0]       state;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] nxt;
  logic [1:0]       mode_q;
  logic [AMT_W-1:0] cnt;
  logic             ob;
  shift_step #(.WIDTH(WIDTH)) u_step (.value(work), .mode(mode_q), .next(nxt), .out_bit(ob));
  assign busy = state != ST_IDLE;
  assign done = state == ST_DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      work      <= '0;
      mode_q    <= MODE_LSL;
      cnt       <= '0;
      Y_shifted <= '0;
      carry_out <= 1'b0;
      zero      <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (start) begin
        work   <= from_Y;
        mode_q <= mode;
        cnt    <= shift_amount;
        if (shift_amount == '0) begin
          state     <= ST_DONE;
          Y_shifted <= from_Y;
          carry_out <= 1'b0;
          zero      <= from_Y == '0;
        end else begin
          state <= ST_SHIFT;
        end
      end
    end else if (state == ST_SHIFT) begin
      work <= nxt;
      cnt  <= cnt - AMT_W'(1);
      if (cnt == AMT_W'(1)) begin
        state     <= ST_DONE;
        Y_shifted <= nxt;
        carry_out <= ob;
        zero      <= nxt == '0;
      end
    end else begin
      state <= ST_IDLE;
    end
  end
endmodule
